// File: rtl/regwrite_arbiter.sv
// Round-robin arbiter that funnels ALU, MUL and MEM results into the
// register bank, PC and CPSR write ports.
// Ports:
//   clk1, rst_n            clock, async active-low reset
//   req[2:0] / gnt[2:0]    requests {MEM,MUL,ALU}, combinational grant
//   alu_*, mul_*, mem_*    per-requester result, destination and flags
//   reg_w/address1/reg_write       register bank write port
//   pc_w/pc_write                  PC write port
//   cpsr_w/cpsr_write/cpsr_mask    CPSR flag write port
//   busy                   high while a write is in progress
module regwrite_arbiter #(
    parameter int unsigned RESET_PTR = 0
) (
    input  logic        clk1,
    input  logic        rst_n,
    input  logic [2:0]  req,
    output logic [2:0]  gnt,
    input  logic [3:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        alu_s,
    input  logic [3:0]  alu_flags,
    input  logic [3:0]  mul_rdhi,
    input  logic [3:0]  mul_rdlo,
    input  logic [63:0] mul_data,
    input  logic        mul_long,
    input  logic        mul_s,
    input  logic [3:0]  mul_flags,
    input  logic [3:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        reg_w,
    output logic [4:0]  address1,
    output logic [31:0] reg_write,
    output logic        pc_w,
    output logic [31:0] pc_write,
    output logic        cpsr_w,
    output logic [31:0] cpsr_write,
    output logic [31:0] cpsr_mask,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, WR_A, WR_B} state_e;

    state_e      state_q;
    logic [1:0]  ptr_q;
    logic [1:0]  ptr_d;
    logic        long_q;
    logic [3:0]  lo_rd_q;
    logic [31:0] lo_data_q;

    logic        ready;
    logic [2:0]  gnt_c;
    logic        xfer;

    // Fields of the granted requester
    logic [3:0]  sel_rd;
    logic [31:0] sel_data;
    logic        sel_s;
    logic [3:0]  sel_flags;
    logic        sel_long;
    logic [3:0]  sel_lo_rd;
    logic [31:0] sel_lo_data;

    // Write to be presented in the next cycle
    logic        wr_en;
    logic [3:0]  wr_rd;
    logic [31:0] wr_data;
    logic        wr_cpsr;
    logic [3:0]  wr_flags;

    always_comb begin
        ready = (state_q == IDLE) ||
                (state_q == WR_A && !long_q) ||
                (state_q == WR_B);
        gnt_c = 3'b000;
        if (ready) begin
            case (ptr_q)
                2'd1: begin
                    if (req[1])      gnt_c = 3'b010;
                    else if (req[2]) gnt_c = 3'b100;
                    else if (req[0]) gnt_c = 3'b001;
                end
                2'd2: begin
                    if (req[2])      gnt_c = 3'b100;
                    else if (req[0]) gnt_c = 3'b001;
                    else if (req[1]) gnt_c = 3'b010;
                end
                default: begin
                    if (req[0])      gnt_c = 3'b001;
                    else if (req[1]) gnt_c = 3'b010;
                    else if (req[2]) gnt_c = 3'b100;
                end
            endcase
        end
        xfer = |gnt_c;
    end

    // Reset forces the grant low even though IDLE is a ready state
    assign gnt  = rst_n ? gnt_c : 3'b000;
    assign busy = (state_q != IDLE);

    always_comb begin
        sel_rd      = alu_rd;
        sel_data    = alu_data;
        sel_s       = alu_s;
        sel_flags   = alu_flags;
        sel_long    = 1'b0;
        sel_lo_rd   = alu_rd;
        sel_lo_data = alu_data;
        ptr_d       = ptr_q;
        unique case (1'b1)
            gnt_c[0]: ptr_d = 2'd1;
            gnt_c[1]: begin
                // Long op writes the high word first
                sel_rd      = mul_long ? mul_rdhi : mul_rdlo;
                sel_data    = mul_long ? mul_data[63:32]
                                       : mul_data[31:0];
                sel_s       = mul_s;
                sel_flags   = mul_flags;
                sel_long    = mul_long;
                sel_lo_rd   = mul_rdlo;
                sel_lo_data = mul_data[31:0];
                ptr_d       = 2'd2;
            end
            gnt_c[2]: begin
                sel_rd    = mem_rd;
                sel_data  = mem_data;
                sel_s     = 1'b0;
                sel_flags = 4'b0000;
                ptr_d     = 2'd0;
            end
            default: ;
        endcase
    end

    always_comb begin
        wr_en    = 1'b0;
        wr_rd    = 4'd0;
        wr_data  = 32'd0;
        wr_cpsr  = 1'b0;
        wr_flags = 4'd0;
        if (xfer) begin
            wr_en    = 1'b1;
            wr_rd    = sel_rd;
            wr_data  = sel_data;
            wr_cpsr  = sel_s;
            wr_flags = sel_flags;
        end else if (state_q == WR_A && long_q) begin
            wr_en   = 1'b1;
            wr_rd   = lo_rd_q;
            wr_data = lo_data_q;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= 2'(RESET_PTR);
            long_q     <= 1'b0;
            lo_rd_q    <= 4'd0;
            lo_data_q  <= 32'd0;
            reg_w      <= 1'b0;
            address1   <= 5'd0;
            reg_write  <= 32'd0;
            pc_w       <= 1'b0;
            pc_write   <= 32'd0;
            cpsr_w     <= 1'b0;
            cpsr_write <= 32'd0;
            cpsr_mask  <= 32'd0;
        end else begin
            if (xfer) begin
                state_q   <= WR_A;
                ptr_q     <= ptr_d;
                long_q    <= sel_long;
                lo_rd_q   <= sel_lo_rd;
                lo_data_q <= sel_lo_data;
            end else if (state_q == WR_A && long_q) begin
                state_q <= WR_B;
                long_q  <= 1'b0;
            end else begin
                state_q <= IDLE;
                long_q  <= 1'b0;
            end
            // R15 is the PC: redirect instead of a bank write
            reg_w      <= wr_en && (wr_rd != 4'd15);
            address1   <= (wr_en && wr_rd != 4'd15)
                          ? {1'b0, wr_rd} : 5'd0;
            reg_write  <= (wr_en && wr_rd != 4'd15)
                          ? wr_data : 32'd0;
            pc_w       <= wr_en && (wr_rd == 4'd15);
            pc_write   <= (wr_en && wr_rd == 4'd15)
                          ? wr_data : 32'd0;
            cpsr_w     <= wr_cpsr;
            cpsr_write <= wr_cpsr ? {wr_flags, 28'd0} : 32'd0;
            cpsr_mask  <= wr_cpsr ? 32'hF000_0000 : 32'd0;
        end
    end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Scoreboard bench for regwrite_arbiter: directed cases followed by
// randomized requester traffic, checked against a transaction model.
module tb_regwrite_arbiter;

    logic        clk1 = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req = '0;
    logic [2:0]  gnt;
    logic [3:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        alu_s = 1'b0;
    logic [3:0]  alu_flags = '0;
    logic [3:0]  mul_rdhi = '0;
    logic [3:0]  mul_rdlo = '0;
    logic [63:0] mul_data = '0;
    logic        mul_long = 1'b0;
    logic        mul_s = 1'b0;
    logic [3:0]  mul_flags = '0;
    logic [3:0]  mem_rd = '0;
    logic [31:0] mem_data = '0;
    logic        reg_w;
    logic [4:0]  address1;
    logic [31:0] reg_write;
    logic        pc_w;
    logic [31:0] pc_write;
    logic        cpsr_w;
    logic [31:0] cpsr_write;
    logic [31:0] cpsr_mask;
    logic        busy;

    regwrite_arbiter dut (
        .clk1(clk1), .rst_n(rst_n), .req(req), .gnt(gnt),
        .alu_rd(alu_rd), .alu_data(alu_data),
        .alu_s(alu_s), .alu_flags(alu_flags),
        .mul_rdhi(mul_rdhi), .mul_rdlo(mul_rdlo),
        .mul_data(mul_data), .mul_long(mul_long),
        .mul_s(mul_s), .mul_flags(mul_flags),
        .mem_rd(mem_rd), .mem_data(mem_data),
        .reg_w(reg_w), .address1(address1),
        .reg_write(reg_write), .pc_w(pc_w),
        .pc_write(pc_write), .cpsr_w(cpsr_w),
        .cpsr_write(cpsr_write), .cpsr_mask(cpsr_mask),
        .busy(busy)
    );

    always #5 clk1 = ~clk1;

    typedef struct packed {
        logic        rw;
        logic [4:0]  a;
        logic [31:0] rd;
        logic        pw;
        logic [31:0] pd;
        logic        cw;
        logic [31:0] cd;
        logic [31:0] cm;
        logic        bz;
    } wr_t;

    wr_t        q[$];
    int         ptr_m = 0;
    logic [2:0] last_g = '0;
    logic [2:0] dut_g = '0;
    int         vectors = 0;
    int         miscompares = 0;

    task automatic chk(input string tag,
                       input logic [159:0] got,
                       input logic [159:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic wr_t obs_now();
        return wr_t'({reg_w, address1, reg_write, pc_w, pc_write,
                      cpsr_w, cpsr_write, cpsr_mask, busy});
    endfunction

    function automatic void push_wr(input logic [3:0] rd,
                                    input logic [31:0] d,
                                    input logic s,
                                    input logic [3:0] f);
        wr_t e;
        e = '0;
        e.bz = 1'b1;
        if (rd == 4'd15) begin
            e.pw = 1'b1;
            e.pd = d;
        end else begin
            e.rw = 1'b1;
            e.a  = {1'b0, rd};
            e.rd = d;
        end
        if (s) begin
            e.cw = 1'b1;
            e.cd = {f, 28'd0};
            e.cm = 32'hF000_0000;
        end
        q.push_back(e);
    endfunction

    function automatic void push_from(input int i);
        case (i)
            0: push_wr(alu_rd, alu_data, alu_s, alu_flags);
            1: begin
                if (mul_long) begin
                    push_wr(mul_rdhi, mul_data[63:32],
                            mul_s, mul_flags);
                    push_wr(mul_rdlo, mul_data[31:0],
                            1'b0, 4'd0);
                end else begin
                    push_wr(mul_rdlo, mul_data[31:0],
                            mul_s, mul_flags);
                end
            end
            default: push_wr(mem_rd, mem_data, 1'b0, 4'd0);
        endcase
    endfunction

    // One clock: check this cycle's outputs and grant, then advance
    task automatic cyc();
        wr_t        e;
        logic [2:0] gm;
        int         gi;
        @(negedge clk1);
        e = '0;
        if (q.size() != 0) e = q.pop_front();
        chk("wr", 160'(obs_now()), 160'(e));
        gm = '0;
        gi = 0;
        if (q.size() == 0) begin
            for (int k = 0; k < 3; k++) begin
                int idx;
                idx = (ptr_m + k) % 3;
                if (gm == '0 && req[idx]) begin
                    gm[idx] = 1'b1;
                    gi = idx;
                end
            end
        end
        dut_g = gnt;
        chk("gnt", 160'(gnt), 160'(gm));
        if (gm != '0) begin
            push_from(gi);
            ptr_m = (gi + 1) % 3;
        end
        last_g = gm;
        @(posedge clk1);
        #1;
    endtask

    task automatic reset_pulse(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, "_out"}, 160'(obs_now()), 160'(0));
        chk({tag, "_gnt"}, 160'(gnt), 160'(0));
        q.delete();
        ptr_m = 0;
        @(posedge clk1);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic rnd(input int i);
        case (i)
            0: begin
                alu_rd    = 4'($urandom_range(0, 15));
                alu_data  = $urandom;
                alu_s     = 1'($urandom_range(0, 1));
                alu_flags = 4'($urandom_range(0, 15));
            end
            1: begin
                mul_rdhi  = 4'($urandom_range(0, 15));
                mul_rdlo  = 4'($urandom_range(0, 15));
                mul_data  = {$urandom, $urandom};
                mul_long  = 1'($urandom_range(0, 1));
                mul_s     = 1'($urandom_range(0, 1));
                mul_flags = 4'($urandom_range(0, 15));
            end
            default: begin
                mem_rd   = 4'($urandom_range(0, 15));
                mem_data = $urandom;
            end
        endcase
    endtask

    initial begin
        logic [17:0] order;
        req = 3'b111;
        @(posedge clk1);
        #1;
        chk("rst_out", 160'(obs_now()), 160'(0));
        chk("rst_gnt", 160'(gnt), 160'(0));
        req = 3'b000;
        @(posedge clk1);
        #1;
        rst_n = 1'b1;

        // ALU with flags
        alu_rd = 4'd3; alu_data = 32'h14;
        alu_s = 1'b1; alu_flags = 4'b0100;
        req = 3'b001;
        cyc();
        req = 3'b000;
        cyc();
        cyc();

        // MUL long; ALU waits through WR_A
        mul_rdhi = 4'd1; mul_rdlo = 4'd2;
        mul_data = 64'h0000_0001_0000_000F;
        mul_long = 1'b1; mul_s = 1'b0;
        req = 3'b010;
        cyc();
        alu_rd = 4'd5; alu_data = 32'hAA; alu_s = 1'b0;
        req = 3'b001;
        cyc();
        cyc();
        req = 3'b000;
        cyc();
        cyc();

        // Round robin from reset pointer
        req = 3'b111;
        reset_pulse("rst_rr");
        alu_rd = 4'd1; mul_rdlo = 4'd2;
        mul_long = 1'b0; mem_rd = 4'd3;
        order = '0;
        repeat (6) begin
            cyc();
            order = {order[14:0], dut_g};
        end
        chk("rr_order", 160'(order),
            160'(18'b001_010_100_001_010_100));
        req = 3'b000;
        cyc();
        cyc();

        // MEM load to PC
        mem_rd = 4'd15; mem_data = 32'h100;
        req = 3'b100;
        cyc();
        req = 3'b000;
        cyc();
        cyc();

        // Long op with rdhi == rdlo and flags
        mul_rdhi = 4'd7; mul_rdlo = 4'd7;
        mul_data = 64'hDEAD_BEEF_1234_5678;
        mul_long = 1'b1; mul_s = 1'b1; mul_flags = 4'b1010;
        req = 3'b010;
        cyc();
        req = 3'b000;
        cyc();
        cyc();
        cyc();

        // Reset in WR_A of a long op
        mul_rdhi = 4'd1; mul_rdlo = 4'd2;
        mul_data = 64'h0000_0001_0000_000F;
        mul_long = 1'b1; mul_s = 1'b0;
        req = 3'b010;
        cyc();
        req = 3'b000;
        reset_pulse("rst_wra");
        cyc();
        cyc();

        // Random traffic; requests held until granted
        repeat (300) begin
            cyc();
            for (int i = 0; i < 3; i++)
                if (last_g[i]) req[i] = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    rnd(i);
                    req[i] = 1'b1;
                end
            end
        end
        req = 3'b000;
        repeat (4) cyc();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regwrite_arbiter.md
REGWRITE_ARBITER -- requirements
Module: regwrite_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as the codebase does: clk1 and rst_n.
REQ-002 Parameter RESET_PTR, default 0: the requester index holding top priority after reset.
REQ-003 clk1  in  1  clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 req  in  3  write requests: [0]=ALU, [1]=MUL, [2]=MEM.
REQ-006 gnt  out  3  combinational grant, one-hot or zero; a transfer occurs on a rising edge with req[i]&gnt[i].
REQ-007 alu_rd  in  4, alu_data  in  32, alu_s  in  1, alu_flags  in  4 {N,Z,C,V}: ALU result and destination.
REQ-008 mul_rdhi  in  4, mul_rdlo  in  4, mul_data  in  64, mul_long  in  1, mul_s  in  1, mul_flags  in  4: multiplier result.
REQ-009 mem_rd  in  4, mem_data  in  32: load data and destination; never sets flags.
REQ-010 reg_w  out  1, address1  out  5, reg_write  out  32: register bank write port.
REQ-011 pc_w  out  1, pc_write  out  32: PC write port.
REQ-012 cpsr_w  out  1, cpsr_write  out  32, cpsr_mask  out  32: CPSR write port.
REQ-013 busy  out  1: high whenever state is not IDLE.

Function
REQ-014 FSM states: IDLE, WR_A, WR_B; every write output is registered.
REQ-015 ready = (IDLE) or (WR_A and latched op not long) or (WR_B).
REQ-016 gnt SHALL be zero unless ready; when ready, gnt selects one active req in round-robin order, starting at ptr and wrapping 2->0.
REQ-017 On a transfer from requester i, ptr SHALL become (i+1) mod 3; ptr is unchanged when no transfer occurs.
REQ-018 On a transfer, the block latches that requester's fields. Next state is WR_A. Idle with no transfer -> IDLE.
REQ-019 WR_A, short op: reg_w=1, address1={1'b0,rd}, reg_write=data, for exactly one cycle.
REQ-020 WR_A, long op (req[1] with mul_long=1): writes mul_data[63:32] to rdhi; then WR_B writes mul_data[31:0] to rdlo. MUL short op writes mul_data[31:0] to mul_rdlo.
REQ-021 Latency: first write cycle is the cycle immediately after the transfer edge. Back-to-back transfers give one write per cycle with no bubble.
REQ-022 Destination 15: in that cycle, pc_w=1 and pc_write=data replace the register write; reg_w stays 0.
REQ-023 When the latched s=1, cpsr_w=1 in WR_A only, with cpsr_write={flags,28'b0} and cpsr_mask=32'hF000_0000. Otherwise cpsr_w=0.
REQ-024 rdhi==rdlo on a long op: both writes occur in order, so the lo value is the final one.
REQ-025 In cycles with no write, reg_w, pc_w and cpsr_w SHALL be 0. address1, reg_write, pc_write, cpsr_write and cpsr_mask SHALL be 0.
REQ-026 Requesters hold req and data stable until the transfer edge. Data is sampled only at the transfer edge.

Reset
REQ-027 rst_n low SHALL force, immediately and asynchronously: state=IDLE, ptr=RESET_PTR, and every output 0, gnt included.
REQ-028 Reset during WR_A or WR_B SHALL abandon the pending write with no partial second write. After release, the first edge accepts new transfers normally.

Verification
REQ-029 ALU req with alu_rd=3, data=0x0000_0014, s=1, flags=4'b0100 -> next cycle: reg_w=1, address1=3, reg_write=0x14, cpsr_w=1, cpsr_write=0x4000_0000.
REQ-030 MUL long, rdhi=1, rdlo=2, data=0x0000_0001_0000_000F -> reg_w high two consecutive cycles: (1, 0x1), then (2, 0xF). gnt stays 0 during WR_A.
REQ-031 req=3'b111 held for 6 grants after reset -> grant order ALU, MUL, MEM, ALU, MUL, MEM, one write per cycle.
REQ-032 MEM req with mem_rd=15, data=0x0000_0100 -> pc_w=1, pc_write=0x100, reg_w=0.
REQ-033 rst_n pulsed low during WR_A of a long MUL -> all outputs 0 at once; no rdlo write after release; busy=0.
